// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : MEM-stage data memory with fixed wait states, byte-lane
//               writes, flush abort and a one-cycle completion pulse.
// Revision    : 1.0
// ============================================================================
module data_mem_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        flush_i,
    output logic [31:0] mem_data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stallreq_o
);

    localparam int         c_DEPTH = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_idx;
    logic [3:0]          r_sel;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [c_DEPTH];

    logic                w_accept;
    logic                w_commit;
    logic                w_we;
    logic [ADDR_W-1:0]   w_idx;
    logic [3:0]          w_sel;
    logic [31:0]         w_wdata;
    logic                w_unused_addr;

    assign w_unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    assign w_accept = (r_state == S_IDLE) && mem_ce_i && !flush_i;

    // With zero wait states the access commits on the accepting edge, so the
    // live inputs stand in for the not-yet-captured request registers.
    assign w_commit = (w_accept && (WAIT_STATES == 0)) ||
                      ((r_state == S_WAIT) && !flush_i && (r_cnt == 4'd1));

    assign w_we    = (r_state == S_IDLE) ? mem_we_i                 : r_we;
    assign w_idx   = (r_state == S_IDLE) ? mem_addr_i[ADDR_W+1:2]   : r_idx;
    assign w_sel   = (r_state == S_IDLE) ? mem_sel_i                : r_sel;
    assign w_wdata = (r_state == S_IDLE) ? mem_data_i               : r_wdata;

    assign stallreq_o = rst && (w_accept || (r_state == S_WAIT));

    // The storage array is deliberately left out of the reset branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_sel      <= 4'd0;
            r_wdata    <= 32'h0;
            mem_data_o <= 32'h0;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;

            if (w_commit) begin
                ack_o <= 1'b1;
                err_o <= (w_sel == 4'd0);
                if (w_sel != 4'd0) begin
                    if (w_we) begin
                        for (int i = 0; i < 4; i++) begin
                            if (w_sel[i]) begin
                                r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                            end
                        end
                    end else begin
                        mem_data_o <= r_mem[w_idx];
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= mem_we_i;
                        r_idx   <= mem_addr_i[ADDR_W+1:2];
                        r_sel   <= mem_sel_i;
                        r_wdata <= mem_data_i;
                        r_cnt   <= c_WAIT;
                        r_state <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_resp
// Description : Directed bench for data_mem_resp (2 and 0 wait-state copies).
// Revision    : 1.0
// ============================================================================
module tb_data_mem_resp;

    logic        clk;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic        flush_i;
    logic [31:0] mem_data_o,  mem_data_o0;
    logic        ack_o,       ack_o0;
    logic        err_o,       err_o0;
    logic        stallreq_o,  stallreq_o0;

    int pass_cnt;
    int total_cnt;

    data_mem_resp #(.ADDR_W(10), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
        .flush_i(flush_i), .mem_data_o(mem_data_o), .ack_o(ack_o),
        .err_o(err_o), .stallreq_o(stallreq_o)
    );

    data_mem_resp #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
        .flush_i(flush_i), .mem_data_o(mem_data_o0), .ack_o(ack_o0),
        .err_o(err_o0), .stallreq_o(stallreq_o0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request for a single cycle and measures the response over a
    // bounded window; cycle 0 is the request cycle.
    task automatic run_access(input bit use0, input logic we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] data,
                              output int stalls, output int ack_cyc, output int acks,
                              output logic err);
        stalls  = 0;
        ack_cyc = -1;
        acks    = 0;
        err     = 1'b0;
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (use0 ? stallreq_o0 : stallreq_o) stalls++;
            if (use0 ? ack_o0 : ack_o) begin
                acks++;
                if (ack_cyc < 0) begin
                    ack_cyc = c;
                    err     = use0 ? err_o0 : err_o;
                end
            end
            @(posedge clk); #1;
            mem_ce_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0;
        mem_sel_i = 4'hF; mem_data_i = 32'h0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({mem_data_o, ack_o, err_o, stallreq_o} !== 35'h0) begin
            $display("FAIL reset_outputs: got data=%h ack=%b err=%b stall=%b, want all 0",
                     mem_data_o, ack_o, err_o, stallreq_o);
        end else pass_cnt++;
        @(posedge clk); #1;
        mem_ce_i = 1'b0; rst = 1'b1;
    endtask

    task automatic test_full_word();
        int s, a, n; logic e;
        run_access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, s, a, n, e);
        total_cnt++;
        if (s !== 3 || a !== 3 || n !== 1 || e !== 1'b0) begin
            $display("FAIL full_write_timing: stall=%0d ack_cyc=%0d acks=%0d err=%b, want 3 3 1 0", s, a, n, e);
        end else pass_cnt++;
        run_access(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, s, a, n, e);
        total_cnt++;
        if (s !== 3 || a !== 3 || n !== 1) begin
            $display("FAIL full_read_timing: stall=%0d ack_cyc=%0d acks=%0d, want 3 3 1", s, a, n);
        end else pass_cnt++;
        total_cnt++;
        if (mem_data_o !== 32'hDEADBEEF) begin
            $display("FAIL full_read_data: got %h want DEADBEEF", mem_data_o);
        end else pass_cnt++;
    endtask

    task automatic test_byte_lane();
        int s, a, n; logic e;
        run_access(1'b0, 1'b1, 32'h20, 4'hF, 32'hAABBCCDD, s, a, n, e);
        run_access(1'b0, 1'b1, 32'h20, 4'b0100, 32'h11111111, s, a, n, e);
        total_cnt++;
        if (mem_data_o !== 32'hDEADBEEF) begin
            $display("FAIL write_keeps_rdata: got %h want DEADBEEF", mem_data_o);
        end else pass_cnt++;
        run_access(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, s, a, n, e);
        total_cnt++;
        if (mem_data_o !== 32'hAA11CCDD) begin
            $display("FAIL byte_lane_data: got %h want AA11CCDD", mem_data_o);
        end else pass_cnt++;
    endtask

    task automatic test_flush();
        int s, a, n; logic e; int acks;
        run_access(1'b0, 1'b1, 32'h30, 4'hF, 32'h0BADF00D, s, a, n, e);
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h30; mem_sel_i = 4'hF;
        mem_data_i = 32'h12345678;
        @(posedge clk); #1;
        mem_ce_i = 1'b0; flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack_o) acks++;
        end
        total_cnt++;
        if (acks !== 0 || stallreq_o !== 1'b0) begin
            $display("FAIL flush_no_ack: acks=%0d stall=%b, want 0 0", acks, stallreq_o);
        end else pass_cnt++;
        total_cnt++;
        if (mem_data_o !== 32'hAA11CCDD) begin
            $display("FAIL flush_keeps_rdata: got %h want AA11CCDD", mem_data_o);
        end else pass_cnt++;
        run_access(1'b0, 1'b0, 32'h30, 4'hF, 32'h0, s, a, n, e);
        total_cnt++;
        if (mem_data_o !== 32'h0BADF00D) begin
            $display("FAIL flush_no_write: got %h want 0BADF00D", mem_data_o);
        end else pass_cnt++;
    endtask

    task automatic test_error();
        int s, a, n; logic e;
        run_access(1'b0, 1'b1, 32'h50, 4'hF, 32'h55AA55AA, s, a, n, e);
        run_access(1'b0, 1'b1, 32'h50, 4'h0, 32'hFFFFFFFF, s, a, n, e);
        total_cnt++;
        if (a !== 3 || n !== 1 || e !== 1'b1) begin
            $display("FAIL sel0_write_err: ack_cyc=%0d acks=%0d err=%b, want 3 1 1", a, n, e);
        end else pass_cnt++;
        run_access(1'b0, 1'b0, 32'h50, 4'hF, 32'h0, s, a, n, e);
        total_cnt++;
        if (mem_data_o !== 32'h55AA55AA || e !== 1'b0) begin
            $display("FAIL sel0_no_write: got %h err=%b want 55AA55AA 0", mem_data_o, e);
        end else pass_cnt++;
        run_access(1'b0, 1'b0, 32'h20, 4'h0, 32'h0, s, a, n, e);
        total_cnt++;
        if (mem_data_o !== 32'h55AA55AA || e !== 1'b1 || n !== 1) begin
            $display("FAIL sel0_read_hold: got %h err=%b acks=%0d want 55AA55AA 1 1", mem_data_o, e, n);
        end else pass_cnt++;
    endtask

    task automatic test_alias();
        int s, a, n; logic e;
        run_access(1'b0, 1'b1, 32'h1000, 4'hF, 32'h13572468, s, a, n, e);
        run_access(1'b0, 1'b0, 32'h0000, 4'hF, 32'h0, s, a, n, e);
        total_cnt++;
        if (mem_data_o !== 32'h13572468) begin
            $display("FAIL alias_data: got %h want 13572468", mem_data_o);
        end else pass_cnt++;
    endtask

    task automatic test_wait_inputs();
        int s, a, n; logic e;
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h60; mem_sel_i = 4'hF;
        mem_data_i = 32'hA5A5F0F0;
        @(posedge clk); #1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h64; mem_sel_i = 4'h1;
        mem_data_i = 32'h0;
        repeat (6) @(posedge clk);
        run_access(1'b0, 1'b0, 32'h60, 4'hF, 32'h0, s, a, n, e);
        total_cnt++;
        if (mem_data_o !== 32'hA5A5F0F0) begin
            $display("FAIL wait_inputs_ignored: got %h want A5A5F0F0", mem_data_o);
        end else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        int s, a, n; logic e;
        run_access(1'b1, 1'b1, 32'h70, 4'hF, 32'h0F1E2D3C, s, a, n, e);
        total_cnt++;
        if (s !== 1 || a !== 1 || n !== 1) begin
            $display("FAIL zero_wait_write: stall=%0d ack_cyc=%0d acks=%0d, want 1 1 1", s, a, n);
        end else pass_cnt++;
        run_access(1'b1, 1'b0, 32'h70, 4'hF, 32'h0, s, a, n, e);
        total_cnt++;
        if (s !== 1 || a !== 1 || mem_data_o0 !== 32'h0F1E2D3C) begin
            $display("FAIL zero_wait_read: stall=%0d ack_cyc=%0d data=%h, want 1 1 0F1E2D3C",
                     s, a, mem_data_o0);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ack_cycles[$];
        logic stall_at3;
        stall_at3 = 1'b1;
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h10; mem_sel_i = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack_o) ack_cycles.push_back(c);
            if (c == 3) stall_at3 = stallreq_o;
        end
        @(posedge clk); #1;
        mem_ce_i = 1'b0;
        repeat (4) @(posedge clk);
        total_cnt++;
        if (ack_cycles.size() !== 2 || ack_cycles[0] !== 3 || ack_cycles[1] !== 7) begin
            $display("FAIL b2b_ack_cycles: count=%0d first=%0d second=%0d, want 2 3 7",
                     ack_cycles.size(),
                     (ack_cycles.size() > 0) ? ack_cycles[0] : -1,
                     (ack_cycles.size() > 1) ? ack_cycles[1] : -1);
        end else pass_cnt++;
        total_cnt++;
        if (stall_at3 !== 1'b0) begin
            $display("FAIL b2b_bubble_stall: got %b want 0", stall_at3);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        int s, a, n; logic e;
        run_access(1'b0, 1'b1, 32'h40, 4'hF, 32'h01020304, s, a, n, e);
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h40; mem_sel_i = 4'hF;
        mem_data_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({mem_data_o, ack_o, err_o, stallreq_o} !== 35'h0) begin
            $display("FAIL reset_mid_wait_outputs: got data=%h ack=%b err=%b stall=%b, want all 0",
                     mem_data_o, ack_o, err_o, stallreq_o);
        end else pass_cnt++;
        @(posedge clk); #1;
        mem_ce_i = 1'b0; rst = 1'b1;
        run_access(1'b0, 1'b0, 32'h40, 4'hF, 32'h0, s, a, n, e);
        total_cnt++;
        if (s !== 3 || a !== 3) begin
            $display("FAIL post_reset_accept: stall=%0d ack_cyc=%0d, want 3 3", s, a);
        end else pass_cnt++;
        total_cnt++;
        if (mem_data_o !== 32'h01020304) begin
            $display("FAIL reset_mid_wait_no_write: got %h want 01020304", mem_data_o);
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_full_word();
        test_byte_lane();
        test_flush();
        test_error();
        test_alias();
        test_wait_inputs();
        test_zero_wait();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL be log2 of the number of 32-bit words in the storage array.
REQ-002 Parameter WAIT_STATES, default 2, SHALL be the number of extra wait cycles per access, legal range 0..15.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 mem_ce_i  input  1  SHALL be the access request from the MEM stage.
REQ-006 mem_we_i  input  1  SHALL select write (1) or read (0).
REQ-007 mem_addr_i  input  32  SHALL be the byte address; word index is mem_addr_i[ADDR_W+1:2], and higher bits are ignored (aliasing).
REQ-008 mem_sel_i  input  4  SHALL be the byte-lane enables, big-endian: sel[3] maps to bits 31:24 and sel[0] maps to bits 7:0.
REQ-009 mem_data_i  input  32  SHALL be the write data, already lane-aligned.
REQ-010 flush_i  input  1  SHALL abort an in-flight access because of a pipeline exception.
REQ-011 mem_data_o  output  32  SHALL be the registered read data.
REQ-012 ack_o  output  1  SHALL be a one-cycle completion pulse.
REQ-013 err_o  output  1  SHALL be a one-cycle error flag, valid only when ack_o=1.
REQ-014 stallreq_o  output  1  SHALL request that the pipeline freeze the MEM stage.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and ACK.
REQ-016 IDLE with mem_ce_i=1 and flush_i=0:
- capture addr, we, sel and data into request registers;
- load the wait counter with WAIT_STATES;
- go to WAIT if WAIT_STATES>0, else go to ACK.
REQ-017 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to ACK on the edge where the counter equals 1.
REQ-018 On the edge that enters ACK:
- a write SHALL update only the lanes with captured sel bits set;
- a read SHALL load mem_data_o with the full addressed word, unmasked.
REQ-019 In ACK, ack_o SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-020 stallreq_o SHALL be combinational and equal 1 when (state==IDLE and mem_ce_i=1 and flush_i=0) or state==WAIT; otherwise it SHALL be 0.
REQ-021 The stall SHALL last exactly WAIT_STATES+1 cycles, and ack_o SHALL assert in cycle WAIT_STATES+1 counted from the request cycle 0.
REQ-022 A request that arrives while the FSM is in ACK SHALL NOT be accepted; it SHALL be sampled in the following IDLE cycle, giving one bubble cycle between back-to-back accesses.
REQ-023 Input changes while in WAIT SHALL be ignored; only captured values SHALL be used.
REQ-024 Captured sel==4'b0000 SHALL complete normally, with ack_o=1, err_o=1, no array write, and mem_data_o unchanged.
REQ-025 flush_i=1 in IDLE SHALL block acceptance of a request.
REQ-026 flush_i=1 in WAIT SHALL send the FSM to IDLE on the next edge with no write, no ack_o and mem_data_o unchanged.
REQ-027 flush_i=1 in ACK SHALL have no effect, because the access has already committed.
REQ-028 mem_data_o SHALL hold its value between reads, and writes SHALL NOT modify it.
REQ-029 The storage array SHALL have 2^ADDR_W words and SHALL NOT be cleared by reset; its contents are undefined until written.

Reset
REQ-030 While rst=0, the outputs SHALL be: state=IDLE, counter=0, mem_data_o=32'h0, ack_o=0, err_o=0, stallreq_o=0.
REQ-031 Reset asserted during WAIT SHALL abort the access with no array write; an access that reached ACK before reset SHALL remain committed.
REQ-032 After rst rises, the first request SHALL be accepted in the first IDLE cycle it is presented.

Verification
REQ-033 Full-word write then read, WAIT_STATES=2:
- write 32'hDEADBEEF to address 0x10 with sel=1111, then read 0x10;
- required: stallreq_o=1 for 3 cycles per access, ack_o in cycle 3, mem_data_o=32'hDEADBEEF.
REQ-034 Byte-lane write:
- write 32'hAABBCCDD to 0x20 with sel=1111;
- then write 32'h11111111 to 0x20 with sel=0100;
- then read 0x20;
- required: mem_data_o=32'hAA11CCDD.
REQ-035 Flush mid-access:
- write 32'h12345678 to 0x30, assert flush_i in the first WAIT cycle, then read 0x30;
- required: no ack_o for the flushed write, and the read returns the prior contents.
REQ-036 Error, aliasing and zero-wait:
- access with sel=0000 -> ack_o=1 with err_o=1, and no write;
- with ADDR_W=10, write to 0x1000 then read 0x0000 -> same data returned (aliasing);
- with WAIT_STATES=0 -> stallreq_o asserted for exactly 1 cycle.
REQ-037 Reset mid-WAIT:
- pull rst low during the WAIT of a write to 0x40 with data 32'hCAFEF00D;
- required: all outputs are 0 while in reset, and a subsequent read of 0x40 does not return 32'hCAFEF00D (provided 0x40 was preloaded with a different value).
